clk_div_monitor: RTL and testbench

- Checker for clocks produced by the team's divide-by-N dividers, including odd-N 50%-duty types.
- Receives the divided clock clk_div, which is generated from clk_in and is synchronous to it, so no synchronizer is used.
- Samples clk_div on both edges of clk_in to get half-cycle resolution.
- Measures period and high time, compares both against expected values, reports lock and sticky error flags.
- Sits beside each divider instance as a built-in self-check, readable by status logic.

---
 rtl/clk_div_pkg.sv | 24 ++
 rtl/clk_div_halfsmp.sv | 29 ++
 rtl/clk_div_monitor.sv | 159 +++++++++++++++
 tb/tb_clk_div_monitor.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the divided-clock monitor.
// Expected values are derived from the division ratio N.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    MEAS   = 2'd2,
    LOCKED = 2'd3
  } state_t;

  function automatic int exp_period(input int n);
    return 2 * n;
  endfunction

  function automatic int exp_high(input int n);
    return n;
  endfunction

  function automatic logic in_tol(input int val, input int exp, input int tol);
    return (val >= exp - tol) && (val <= exp + tol);
  endfunction

endpackage

// File: rtl/clk_div_halfsmp.sv
// Dual-edge sampler: presents the two half-samples of clk_div taken since the
// previous posedge of clk_in, oldest in bit 0, plus their rising-edge flags.
module clk_div_halfsmp (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       clk_div,
  output logic [1:0] smp,
  output logic [1:0] rise
);

  logic neg_smp;
  logic last_smp;

  always_ff @(negedge clk_in) begin
    if (!rst_n) neg_smp <= 1'b0;
    else        neg_smp <= clk_div;
  end

  // last_smp is the newer half-sample of the previous posedge, i.e. the
  // predecessor of neg_smp in the half-sample stream.
  always_ff @(posedge clk_in) begin
    if (!rst_n) last_smp <= 1'b0;
    else        last_smp <= clk_div;
  end

  assign smp  = {clk_div, neg_smp};
  assign rise = {clk_div & ~neg_smp, neg_smp & ~last_smp};

endmodule

// File: rtl/clk_div_monitor.sv
// Built-in self-check for divide-by-N clocks: measures period and high time of
// clk_div in half-cycles of clk_in and reports lock plus sticky error flags.
module clk_div_monitor
  import clk_div_pkg::*;
#(
  parameter int N        = 5,
  parameter int CNT_W    = 8,
  parameter int TOL      = 0,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 4 * N
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             clk_div,
  input  logic             enable,
  input  logic             clr_err,
  output logic [CNT_W-1:0] period_half,
  output logic [CNT_W-1:0] high_half,
  output logic             meas_valid,
  output logic             locked,
  output logic             err_period,
  output logic             err_duty,
  output logic             err_stuck
);

  localparam int               EXP_PERIOD = exp_period(N);
  localparam int               EXP_HIGH   = exp_high(N);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LOCK_C     = CNT_W'(LOCK_CNT);

  logic [1:0]       smp;
  logic [1:0]       rise;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic [CNT_W-1:0] stuck_q, stuck_d;
  logic [CNT_W-1:0] match_q, match_d;
  logic [CNT_W-1:0] period_out_d, high_out_d;
  logic             locked_d, meas_d;
  logic             new_period, new_duty, new_stuck;
  logic             per_ok, high_ok;

  clk_div_halfsmp u_halfsmp (
    .clk_in  (clk_in),
    .rst_n   (rst_n),
    .clk_div (clk_div),
    .smp     (smp),
    .rise    (rise)
  );

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Walk the two half-samples of this posedge in time order; a rising edge
  // closes the running measurement and opens the next one.
  always_comb begin
    state_d      = (state_q == IDLE) ? ACQ : state_q;
    per_d        = per_q;
    high_d       = high_q;
    stuck_d      = stuck_q;
    match_d      = match_q;
    period_out_d = period_half;
    high_out_d   = high_half;
    locked_d     = locked;
    meas_d       = 1'b0;
    new_period   = 1'b0;
    new_duty     = 1'b0;
    new_stuck    = 1'b0;
    per_ok       = 1'b0;
    high_ok      = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (rise[i]) begin
        stuck_d = '0;
        if (state_d == MEAS || state_d == LOCKED) begin
          period_out_d = per_d;
          high_out_d   = high_d;
          meas_d       = 1'b1;
          per_ok       = in_tol(int'(per_d), EXP_PERIOD, TOL);
          high_ok      = in_tol(int'(high_d), EXP_HIGH, TOL);
          if (per_ok && high_ok) begin
            match_d = sat_inc(match_d);
            if (match_d >= LOCK_C) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end
          end else begin
            new_period = new_period | ~per_ok;
            new_duty   = new_duty | ~high_ok;
            match_d    = '0;
            state_d    = MEAS;
            locked_d   = 1'b0;
          end
        end else begin
          state_d = MEAS;
        end
        per_d  = {{(CNT_W-1){1'b0}}, 1'b1};
        high_d = {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stuck_d = sat_inc(stuck_d);
        per_d   = sat_inc(per_d);
        if (smp[i]) high_d = sat_inc(high_d);
        if (stuck_d >= TIMEOUT_C) begin
          new_stuck = 1'b1;
          locked_d  = 1'b0;
          state_d   = ACQ;
          per_d     = '0;
          high_d    = '0;
          stuck_d   = '0;
          match_d   = '0;
        end
      end
    end
  end

  // A new error in the same cycle as clr_err wins, so the flag stays set.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      per_q       <= '0;
      high_q      <= '0;
      stuck_q     <= '0;
      match_q     <= '0;
      period_half <= '0;
      high_half   <= '0;
      meas_valid  <= 1'b0;
      locked      <= 1'b0;
      err_period  <= 1'b0;
      err_duty    <= 1'b0;
      err_stuck   <= 1'b0;
    end else if (!enable) begin
      state_q    <= IDLE;
      per_q      <= '0;
      high_q     <= '0;
      stuck_q    <= '0;
      match_q    <= '0;
      meas_valid <= 1'b0;
      locked     <= 1'b0;
      err_period <= err_period & ~clr_err;
      err_duty   <= err_duty & ~clr_err;
      err_stuck  <= err_stuck & ~clr_err;
    end else begin
      state_q     <= state_d;
      per_q       <= per_d;
      high_q      <= high_d;
      stuck_q     <= stuck_d;
      match_q     <= match_d;
      period_half <= period_out_d;
      high_half   <= high_out_d;
      meas_valid  <= meas_d;
      locked      <= locked_d;
      err_period  <= (err_period & ~clr_err) | new_period;
      err_duty    <= (err_duty & ~clr_err) | new_duty;
      err_stuck   <= (err_stuck & ~clr_err) | new_stuck;
    end
  end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Scoreboard bench for clk_div_monitor: a half-sample stream drives clk_div and
// a history-based reference model predicts every measurement and flag.
module tb_clk_div_monitor;

  localparam int N        = 5;
  localparam int CNT_W    = 8;
  localparam int TOL      = 0;
  localparam int LOCK_CNT = 4;
  localparam int TIMEOUT  = 4 * N;

  logic             clk_in;
  logic             rst_n;
  logic             clk_div;
  logic             enable;
  logic             clr_err;
  logic [CNT_W-1:0] period_half;
  logic [CNT_W-1:0] high_half;
  logic             meas_valid;
  logic             locked;
  logic             err_period;
  logic             err_duty;
  logic             err_stuck;

  typedef struct {
    bit v;
    bit clr;
  } item_t;

  typedef struct {
    int p;
    int h;
  } meas_t;

  item_t stim_q[$];
  bit    hist[$];
  meas_t exp_q[$];

  int tests_run = 0;
  int tests_failed = 0;

  bit model_ready = 0;
  bit m_active, m_started, m_pred_zero;
  int m_start, m_ref, m_good;
  bit exp_mv, exp_locked, exp_ep, exp_ed, exp_es;
  int exp_p, exp_h;

  clk_div_monitor #(
    .N        (N),
    .CNT_W    (CNT_W),
    .TOL      (TOL),
    .LOCK_CNT (LOCK_CNT),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .clk_div     (clk_div),
    .enable      (enable),
    .clr_err     (clr_err),
    .period_half (period_half),
    .high_half   (high_half),
    .meas_valid  (meas_valid),
    .locked      (locked),
    .err_period  (err_period),
    .err_duty    (err_duty),
    .err_stuck   (err_stuck)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic check(input string name, input logic [31:0] act, input int exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_item(input bit v, input bit clr);
    item_t it;
    it.v = v;
    it.clr = clr;
    stim_q.push_back(it);
  endtask

  // One clk_div period of hi ones then lo zeros; bit i of clr_mask requests
  // clr_err at the posedge that consumes half-sample i of this period.
  task automatic apply_stimulus(input int hi, input int lo, input logic [31:0] clr_mask);
    for (int i = 0; i < hi + lo; i++) push_item(i < hi, (i < 32) && clr_mask[i]);
  endtask

  task automatic apply_const(input bit v, input int len);
    for (int i = 0; i < len; i++) push_item(v, 1'b0);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 5000 && stim_q.size() > 0; i++) @(posedge clk_in);
    check("stim_drain", stim_q.size(), 0);
  endtask

  // Half-sample driver: a new clk_div value shortly after every clk_in edge.
  initial begin
    item_t a;
    bit cur;
    cur = 1'b0;
    clk_div = 1'b0;
    clr_err = 1'b0;
    forever begin
      @(posedge clk_in);
      #1;
      clr_err = 1'b0;
      if (stim_q.size() > 0) begin
        a = stim_q.pop_front();
        cur = a.v;
        clr_err = a.clr;
        if (stim_q.size() > 0 && stim_q[0].clr) clr_err = 1'b1;
      end
      clk_div = cur;
      hist.push_back(cur);
      @(negedge clk_in);
      #1;
      if (stim_q.size() > 0) begin
        a = stim_q.pop_front();
        cur = a.v;
      end
      clk_div = cur;
      hist.push_back(cur);
    end
  end

  // Reference model over the recorded half-sample history: periods are index
  // distances between rising edges, high time is the count of ones between them.
  task automatic model_step();
    int  n, k, p, h;
    bit  v, pred, p_ok, h_ok, mv, new_p, new_d, new_s;
    model_ready = 1;
    mv = 0;
    new_p = 0;
    new_d = 0;
    new_s = 0;
    if (!rst_n) begin
      m_active = 0;
      m_started = 0;
      m_good = 0;
      m_pred_zero = 1;
      exp_mv = 0;
      exp_locked = 0;
      exp_ep = 0;
      exp_ed = 0;
      exp_es = 0;
      exp_p = 0;
      exp_h = 0;
      return;
    end
    if (!enable) begin
      m_active = 0;
      m_started = 0;
      m_good = 0;
      exp_locked = 0;
    end else begin
      n = hist.size();
      if (!m_active) begin
        m_active = 1;
        m_ref = n - 3;
      end
      for (int j = 0; j < 2; j++) begin
        k = n - 2 + j;
        v = hist[k];
        pred = (j == 0 && m_pred_zero) || k < 1 ? 1'b0 : hist[k-1];
        if (v && !pred) begin
          if (m_started) begin
            p = k - m_start;
            h = 0;
            for (int i = m_start; i < k; i++) h += int'(hist[i]);
            p_ok = (p >= 2 * N - TOL) && (p <= 2 * N + TOL);
            h_ok = (h >= N - TOL) && (h <= N + TOL);
            exp_p = p;
            exp_h = h;
            mv = 1;
            if (p_ok && h_ok) begin
              m_good++;
              if (m_good >= LOCK_CNT) exp_locked = 1;
            end else begin
              new_p |= !p_ok;
              new_d |= !h_ok;
              m_good = 0;
              exp_locked = 0;
            end
          end
          m_started = 1;
          m_start = k;
          m_ref = k;
        end else if (k - m_ref >= TIMEOUT) begin
          new_s = 1;
          exp_locked = 0;
          m_started = 0;
          m_good = 0;
          m_ref = k;
        end
      end
    end
    m_pred_zero = 0;
    exp_ep = (exp_ep & !clr_err) | new_p;
    exp_ed = (exp_ed & !clr_err) | new_d;
    exp_es = (exp_es & !clr_err) | new_s;
    exp_mv = mv;
    if (mv) exp_q.push_back('{p: exp_p, h: exp_h});
  endtask

  initial begin
    forever begin
      @(posedge clk_in);
      model_step();
    end
  end

  task automatic check_output();
    meas_t m;
    check("meas_valid", meas_valid, exp_mv);
    if (meas_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("scoreboard_nonempty", 0, 1);
      end else begin
        m = exp_q.pop_front();
        check("period_half_meas", period_half, m.p);
        check("high_half_meas", high_half, m.h);
      end
    end
    check("period_half", period_half, exp_p);
    check("high_half", high_half, exp_h);
    check("locked", locked, exp_locked);
    check("err_period", err_period, exp_ep);
    check("err_duty", err_duty, exp_ed);
    check("err_stuck", err_stuck, exp_es);
  endtask

  initial begin
    forever begin
      @(negedge clk_in);
      if (model_ready) check_output();
    end
  end

  initial begin
    int hi, lo;
    logic [31:0] mask;
    rst_n = 1'b0;
    enable = 1'b0;
    repeat (3) @(posedge clk_in);
    #1 rst_n = 1'b1;
    @(posedge clk_in);
    #1 enable = 1'b1;

    // Nominal 50% duty, then a short-duty period, then a stretched period.
    repeat (8) apply_stimulus(N, N, 0);
    apply_stimulus(N - 1, N + 1, 0);
    repeat (6) apply_stimulus(N, N, 0);
    apply_stimulus(N, N + 2, 0);
    repeat (2) apply_stimulus(N, N, 0);
    // Clear alone, then clear colliding with a fresh duty error, then clear alone.
    apply_stimulus(N, N, 32'h4);
    repeat (4) apply_stimulus(N, N, 0);
    apply_stimulus(N - 1, N + 1, 0);
    apply_stimulus(N, N, 32'h5);
    repeat (5) apply_stimulus(N, N, 0);
    // Stuck low after lock, then stuck high.
    apply_const(1'b0, 30);
    repeat (6) apply_stimulus(N, N, 0);
    apply_const(1'b1, 26);
    apply_const(1'b0, 3);
    repeat (6) apply_stimulus(N, N, 0);
    wait_drain();

    // Randomized periods, mostly nominal.
    for (int r = 0; r < 40; r++) begin
      if ($urandom_range(0, 3) == 0) begin
        hi = $urandom_range(1, 11);
        lo = $urandom_range(1, 11);
      end else begin
        hi = N;
        lo = N;
      end
      mask = ($urandom_range(0, 7) == 0) ? 32'h1 << $urandom_range(0, 3) : 32'h0;
      apply_stimulus(hi, lo, mask);
    end
    wait_drain();

    // Reset pulse in mid-period.
    repeat (8) apply_stimulus(N, N, 0);
    repeat (23) @(posedge clk_in);
    #1 rst_n = 1'b0;
    @(posedge clk_in);
    #1 rst_n = 1'b1;
    wait_drain();

    // Enable dropped for three cycles in mid-period.
    repeat (8) apply_stimulus(N, N, 0);
    repeat (27) @(posedge clk_in);
    #1 enable = 1'b0;
    repeat (3) @(posedge clk_in);
    #1 enable = 1'b1;
    wait_drain();

    repeat (6) apply_stimulus(N, N, 0);
    wait_drain();
    repeat (30) @(posedge clk_in);
    @(negedge clk_in);
    #1;
    check("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
